// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state encoding for the data-memory responder.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Data storage: synchronous write, combinational read, async clear.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: one outstanding lw/sw with fixed access latency.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    dmem_state_t       state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .addr_i  (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = !in_range;
                    rdata_d = '0;
                    if (write_q) begin
                        mem_we = in_range;
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end else begin
                        if (in_range) rdata_d = mem_rdata;
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                // Completion edge never accepts; CPU sees req_ready next cycle
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one DUT with DEPTH=128/LATENCY=2, one with CNT_W=4/LATENCY=1.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [15:0] rd_count, wr_count;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [7:0]  b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [7:0]  b_rsp_rdata;
    logic [3:0]  b_rd_count, b_wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(128), .LATENCY(2), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    data_mem_responder #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Full transaction on dut_a; lat = edges from acceptance to rsp_valid
    task automatic txn(input logic w, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic e, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w;
        req_addr = 8'hEE; req_wdata = 8'hEE;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata; e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    vec_t       vecs [10];
    logic [7:0] rd;
    logic       e;
    int         lat;
    int         seen;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
        b_rsp_ready = 0;

        vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'hFF, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'h7F, 8'hA5, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'h7F, 8'h00, 8'hA5, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h3C, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};
        vecs[9] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};

        #2;
        chk("init_req_ready", 32'(req_ready), 32'd1);
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_clr", i), 32'({rsp_valid, rsp_rdata, rsp_err}),
                32'd0);
        end
        chk("tbl_wr_count", 32'(wr_count), 32'd4);
        chk("tbl_rd_count", 32'(rd_count), 32'd6);

        // Backpressure on a load of 0x5A with noisy request inputs
        req_write = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", i), 32'(rsp_rdata), 32'h5A);
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            req_valid = ~req_valid;
            req_addr = 8'($urandom_range(0, 127));
            @(posedge clk); #1;
        end
        req_valid = 1'b1; req_addr = 8'h00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_done_ready", 32'(req_ready), 32'd1);
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_rdata", 32'(rsp_rdata), 32'd0);
        req_valid = 1'b0;
        chk("bp_rd_count", 32'(rd_count), 32'd7);

        // Abort a pending store with an asynchronous reset
        txn(1'b1, 8'h20, 8'h11, rd, e, lat);
        chk("pre_abort_err", 32'(e), 32'd0);
        req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h33;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        txn(1'b0, 8'h20, 8'h00, rd, e, lat);
        chk("abort_rdata", 32'(rd), 32'h00);
        chk("abort_wr_count", 32'(wr_count), 32'd0);

        // Saturating read counter with single-cycle latency
        for (int i = 0; i < 17; i++) begin
            b_req_write = 1'b0; b_req_addr = 8'(i); b_req_valid = 1'b1;
            @(posedge clk); #1;
            b_req_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("b%0d_lat1", i), 32'(b_rsp_valid), 32'd1);
            b_rsp_ready = 1'b1;
            @(posedge clk); #1;
            b_rsp_ready = 1'b0;
            if (i == 14) chk("b_rd_count_15", 32'(b_rd_count), 32'd15);
        end
        chk("b_rd_count_sat", 32'(b_rd_count), 32'd15);
        chk("b_wr_count", 32'(b_wr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
